// File: rtl/mem_responder_pkg.sv
// Shared constants for the cache/memory path: FSM state encodings and default widths.
package mem_responder_pkg;

    localparam int unsigned DEF_DATA_SIZE = 64;
    localparam int unsigned CNT_W         = 4;

    // Cache and memory-responder states share one 3-bit space without overlapping codes.
    typedef enum logic [2:0] {
        CACHE_IDLE      = 3'd0,
        CACHE_COMPARE   = 3'd1,
        CACHE_ALLOCATE  = 3'd2,
        CACHE_WRITEBACK = 3'd3
    } cache_state_e;

    typedef enum logic [2:0] {
        MEM_IDLE      = 3'd4,
        MEM_BUSY      = 3'd5,
        MEM_RESP      = 3'd6,
        MEM_WAIT_DROP = 3'd7
    } mem_state_e;

endpackage

// File: rtl/mem_responder_latency_counter.sv
// Loadable latency down-counter with a zero flag; it saturates at zero.
module mem_latency_counter
    import mem_responder_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory model answering a cache's level-held read/write requests.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 17,
    parameter int unsigned DATA_SIZE  = DEF_DATA_SIZE,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                 memClock,
    input  logic                 reset,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic [ADDR_SIZE-1:0] memAddress,
    input  logic [DATA_SIZE-1:0] memWrData,
    output logic [DATA_SIZE-1:0] memData,
    output logic                 memReady,
    output logic                 memBusy,
    output logic                 memErr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_SIZE-1:0]  r_mem [DEPTH];
    mem_state_e            r_state;
    mem_state_e            w_state_nxt;
    logic                  r_op_write;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DATA_SIZE-1:0]  r_wdata;
    logic [DATA_SIZE-1:0]  r_rdata;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_load;
    logic                  w_dec;
    logic                  w_zero;
    logic                  w_err;
    logic                  w_resp;
    logic                  w_unused_addr;

    // Upper address bits alias onto the same storage index.
    assign w_unused_addr = ^memAddress[ADDR_SIZE-1:DEPTH_LOG2];

    mem_latency_counter #(
        .W (CNT_W)
    ) u_latency_counter (
        .clk        (memClock),
        .rst_n      (reset),
        .i_load     (w_load),
        .i_load_val (CNT_W'(LATENCY - 1)),
        .i_dec      (w_dec),
        .o_zero_c   (w_zero)
    );

    always_ff @(posedge memClock or negedge reset) begin
        if (!reset) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_err       = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (memRead && memWrite) begin
                    w_err       = 1'b1;
                    w_state_nxt = MEM_WAIT_DROP;
                end else if (memRead || memWrite) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = MEM_BUSY;
                end
            end
            MEM_BUSY: begin
                if (w_zero) begin
                    w_state_nxt = MEM_RESP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            MEM_RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = MEM_WAIT_DROP;
            end
            MEM_WAIT_DROP: begin
                // Hold off until the cache releases the request so it is not taken twice.
                if (!memRead && !memWrite) begin
                    w_state_nxt = MEM_IDLE;
                end
            end
            default: begin
                w_state_nxt = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge memClock or negedge reset) begin
        if (!reset) begin
            r_op_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_write <= memWrite;
                r_idx      <= memAddress[DEPTH_LOG2-1:0];
                r_wdata    <= memWrData;
            end
            if (w_resp && !r_op_write) begin
                r_rdata <= r_mem[r_idx];
            end
            r_ready <= w_resp;
            r_err   <= w_err;
            r_busy  <= (w_state_nxt == MEM_BUSY) || (w_state_nxt == MEM_RESP);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge memClock) begin
        if (w_resp && r_op_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign memData  = r_rdata;
    assign memReady = r_ready;
    assign memBusy  = r_busy;
    assign memErr   = r_err;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_SIZE, default 17: width of memAddress (word address).
REQ-002 Parameter DATA_SIZE, default 64: width of a memory word.
REQ-003 Parameter DEPTH_LOG2, default 10: storage holds 2**DEPTH_LOG2 words, indexed by memAddress[DEPTH_LOG2-1:0]; upper address bits ignored.
REQ-004 Parameter LATENCY, default 4, legal range 1..15: cycles from request acceptance to memReady.
REQ-005 memClock  input  1  sole clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 memRead  input  1  read request from cache, level, held until memReady seen.
REQ-008 memWrite  input  1  write request from cache, level, held until memReady seen.
REQ-009 memAddress  input  ADDR_SIZE  request word address.
REQ-010 memWrData  input  DATA_SIZE  write data, valid with memWrite.
REQ-011 memData  output  DATA_SIZE  read data, valid in the memReady cycle of a read.
REQ-012 memReady  output  1  one-cycle completion pulse.
REQ-013 memBusy  output  1  high while a request is in flight.
REQ-014 memErr  output  1  one-cycle pulse on illegal request.

Function
REQ-015 FSM states: MEM_IDLE, MEM_BUSY, MEM_RESP, MEM_WAIT_DROP.
REQ-016 MEM_IDLE: exactly one of memRead/memWrite high -> capture memAddress, memWrData, op; load counter with LATENCY-1; go MEM_BUSY; memBusy high next cycle.
REQ-017 MEM_IDLE with memRead and memWrite both high: no access, memErr pulses next cycle, go MEM_WAIT_DROP.
REQ-018 MEM_BUSY: counter decrements each cycle; at 0 go MEM_RESP; request inputs ignored, captured values used.
REQ-019 MEM_RESP (one cycle): memReady=1; read -> memData = stored word at captured index; write -> captured data committed to storage at this edge; next state MEM_WAIT_DROP.
REQ-020 Total latency: memReady asserted exactly LATENCY+1 cycles after the accepting edge.
REQ-021 MEM_WAIT_DROP: stay until memRead=0 and memWrite=0, then MEM_IDLE; prevents double acceptance of a held request.
REQ-022 A request asserted in the same cycle the FSM enters MEM_IDLE is accepted only at the following edge.
REQ-023 memData holds the last read value until next read completion; writes do not change memData.
REQ-024 Read after write to same index returns the newly written word.
REQ-025 memBusy = 1 in MEM_BUSY and MEM_RESP, 0 otherwise.

Reset
REQ-026 reset low: state MEM_IDLE, counter 0, memReady 0, memBusy 0, memErr 0, memData 0, captured regs 0.
REQ-027 reset mid-operation aborts the request; a write not yet in MEM_RESP is never committed.
REQ-028 Storage array contents are not reset.

Structure
REQ-029 State encodings MEM_IDLE..MEM_WAIT_DROP and DATA_SIZE default live in the shared define include, alongside existing cache state constants, with non-colliding values.
REQ-030 Latency down-counter is sub-module mem_latency_counter (load, decrement, zero flag); storage array and FSM stay in mem_responder.

Verification
REQ-031 Write 0xDEADBEEF_CAFEF00D at addr 0x005, LATENCY=4 -> memReady 5 cycles after accept, memData unchanged; then read 0x005 -> memData=0xDEADBEEF_CAFEF00D with memReady.
REQ-032 memRead and memWrite both high -> memErr one cycle, no memReady, storage at addr unchanged; deassert -> returns to MEM_IDLE.
REQ-033 Cache holds memRead 3 cycles past memReady -> exactly one memReady; next read accepted only after drop.
REQ-034 Write to 0x00A, reset low in 2nd MEM_BUSY cycle -> all outputs 0; read 0x00A returns prior contents.
REQ-035 Address 0x1_0003 with DEPTH_LOG2=10 -> aliases index 0x003 (write then read via 0x003 matches).
REQ-036 LATENCY=1 back-to-back read/write sequence -> memReady 2 cycles after each accept, memBusy pattern matches REQ-025.
